psum_accumulator: RTL

PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

---
 rtl/psum_accumulator_if.sv | 35 +++
 rtl/psum_accumulator.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/psum_accumulator_if.sv
// Handshake and bus bundle for the partial-sum accumulator: pass control,
// lane results from the systolic array, and the drain port toward the consumer.
interface psum_accumulator_if #(
  parameter int N_COLS_ARRAY        = 16,
  parameter int RES_WIDTH           = 16,
  parameter int ACC_WIDTH           = 24,
  parameter int DEPTH               = 64,
  parameter int COUNTER_ROUND_WIDTH = 3
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PIX_W  = ADDR_W + 1;

  logic                                start_i;
  logic [COUNTER_ROUND_WIDTH-1:0]      n_round_i;
  logic [PIX_W-1:0]                    n_pixels_i;
  logic                                result_valid_i;
  logic [N_COLS_ARRAY*RES_WIDTH-1:0]   result_i;
  logic                                acc_ready_o;
  logic                                out_valid_o;
  logic                                out_ready_i;
  logic [N_COLS_ARRAY*ACC_WIDTH-1:0]   out_data_o;
  logic [ADDR_W-1:0]                   out_addr_o;
  logic                                busy_o;
  logic                                done_o;

  modport slave (
    input  start_i, n_round_i, n_pixels_i, result_valid_i, result_i, out_ready_i,
    output acc_ready_o, out_valid_o, out_data_o, out_addr_o, busy_o, done_o
  );

  modport master (
    output start_i, n_round_i, n_pixels_i, result_valid_i, result_i, out_ready_i,
    input  acc_ready_o, out_valid_o, out_data_o, out_addr_o, busy_o, done_o
  );
endinterface

// File: rtl/psum_accumulator.sv
// Partial-sum accumulator: sums lane results over several weight rounds into a
// per-pixel buffer, then drains the buffer pixel by pixel through a
// valid/ready port and pulses done_o once the pass is complete.
module psum_accumulator #(
  parameter int N_COLS_ARRAY        = 16,
  parameter int RES_WIDTH           = 16,
  parameter int ACC_WIDTH           = 24,
  parameter int DEPTH               = 64,
  parameter int COUNTER_ROUND_WIDTH = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  psum_accumulator_if.slave    bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PIX_W  = ADDR_W + 1;
  localparam int DATA_W = N_COLS_ARRAY * ACC_WIDTH;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_e;

  state_e                         state_q, state_d;
  logic [ADDR_W-1:0]              wrPtr_q, wrPtr_d;
  logic [ADDR_W-1:0]              rdPtr_q, rdPtr_d;
  logic [ADDR_W-1:0]              pixLast_q, pixLast_d;
  logic [COUNTER_ROUND_WIDTH-1:0] round_q, round_d;
  logic [COUNTER_ROUND_WIDTH-1:0] roundLast_q, roundLast_d;

  logic [DATA_W-1:0]              buffer_q [DEPTH];

  logic                           startOk;
  logic                           beat;
  logic [DATA_W-1:0]              wrBase;
  logic [DATA_W-1:0]              wrEntry;
  logic [DATA_W-1:0]              rdEntry;
  logic signed [RES_WIDTH-1:0]    laneRes;
  logic signed [ACC_WIDTH-1:0]    laneExt;

  assign startOk = bus.start_i && (bus.n_pixels_i != '0) && (bus.n_pixels_i <= PIX_W'(DEPTH));
  assign beat    = rst_n_i && (state_q == ACCUM) && bus.result_valid_i;

  // Per lane: sign-extend the incoming result and add it to the stored sum, except in round 0 where it overwrites
  always_comb begin
    wrBase  = buffer_q[wrPtr_q];
    rdEntry = buffer_q[rdPtr_q];
    wrEntry = '0;
    laneRes = '0;
    laneExt = '0;
    for (int k = 0; k < N_COLS_ARRAY; k++) begin
      laneRes = bus.result_i[k*RES_WIDTH +: RES_WIDTH];
      laneExt = laneRes;
      wrEntry[k*ACC_WIDTH +: ACC_WIDTH] = laneExt +
        ((round_q == '0) ? {ACC_WIDTH{1'b0}} : wrBase[k*ACC_WIDTH +: ACC_WIDTH]);
    end
  end

  // Buffer write port; contents are left alone by reset since round 0 always overwrites
  always_ff @(posedge clk_i) begin
    if (beat) begin
      buffer_q[wrPtr_q] <= wrEntry;
    end
  end

  // Next-state, pointer/round bookkeeping and port outputs for the pass sequencer
  always_comb begin
    state_d         = state_q;
    wrPtr_d         = wrPtr_q;
    rdPtr_d         = rdPtr_q;
    round_d         = round_q;
    pixLast_d       = pixLast_q;
    roundLast_d     = roundLast_q;
    bus.acc_ready_o = 1'b0;
    bus.out_valid_o = 1'b0;
    bus.out_data_o  = '0;
    bus.out_addr_o  = '0;
    bus.busy_o      = (state_q != IDLE);
    bus.done_o      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (startOk) begin
          state_d     = ACCUM;
          pixLast_d   = ADDR_W'(bus.n_pixels_i - PIX_W'(1));
          roundLast_d = (bus.n_round_i == '0) ? '0
                                              : bus.n_round_i - COUNTER_ROUND_WIDTH'(1);
          wrPtr_d     = '0;
          rdPtr_d     = '0;
          round_d     = '0;
        end
      end
      ACCUM: begin
        bus.acc_ready_o = 1'b1;
        if (bus.result_valid_i) begin
          if (wrPtr_q == pixLast_q) begin
            wrPtr_d = '0;
            if (round_q == roundLast_q) begin
              state_d = DRAIN;
              rdPtr_d = '0;
              round_d = '0;
            end else begin
              round_d = round_q + COUNTER_ROUND_WIDTH'(1);
            end
          end else begin
            wrPtr_d = wrPtr_q + ADDR_W'(1);
          end
        end
      end
      DRAIN: begin
        bus.out_valid_o = 1'b1;
        bus.out_data_o  = rdEntry;
        bus.out_addr_o  = rdPtr_q;
        if (bus.out_ready_i) begin
          if (rdPtr_q == pixLast_q) begin
            state_d = DONE;
          end else begin
            rdPtr_d = rdPtr_q + ADDR_W'(1);
          end
        end
      end
      DONE: begin
        bus.done_o = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and bookkeeping registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      round_q     <= '0;
      pixLast_q   <= '0;
      roundLast_q <= '0;
    end else begin
      state_q     <= state_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      round_q     <= round_d;
      pixLast_q   <= pixLast_d;
      roundLast_q <= roundLast_d;
    end
  end
endmodule
